image_mem_packer: RTL and testbench
===================================

IMAGE_MEM_PACKER -- requirements
Module: image_mem_packer

Interface
REQ-001 Parameter ADDR_W, default 13, SHALL be the image memory word-address width (8192 words).
REQ-002 Parameter LEN_W, default 14, SHALL be the word-count width (0..8192 words per transfer).
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: single-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 Port base_addr, input, ADDR_W: first memory word address, captured when start is accepted.
REQ-007 Port num_words, input, LEN_W: number of 1024-bit words to write, captured when start is accepted.
REQ-008 Port in_valid, input, 1: a complex sample is present on in_r/in_i.
REQ-009 Port in_ready, output, 1: the packer accepts a sample this cycle.
REQ-010 Port in_r, input, 32: real part of the sample.
REQ-011 Port in_i, input, 32: imaginary part of the sample.
REQ-012 Port wr, output, 1: memory write enable, one cycle per packed word.
REQ-013 Port waddr, output, ADDR_W: memory write address, valid while wr=1.
REQ-014 Port wdata, output, 1024: packed word of 16 complex lanes, valid while wr=1.
REQ-015 Port busy, output, 1: high from accepted start until done.
REQ-016 Port done, output, 1: single-cycle pulse when the transfer completes.

Function
REQ-017 States SHALL be IDLE, FILL, LAST, DONE.
REQ-018 IDLE: in_ready=0; start=1 with num_words>0 SHALL capture base_addr/num_words, clear lane and word counters, and go to FILL.
REQ-019 IDLE: start=1 with num_words=0 SHALL go directly to DONE; no write is issued.
REQ-020 FILL: in_ready=1; a sample is accepted when in_valid=1 and in_ready=1 in the same cycle.
REQ-021 Sample k (k=0..15, order of acceptance) SHALL be placed at lane k: wdata[64k+31:64k]=in_r, wdata[64k+63:64k+32]=in_i, i.e. row k/4, column k mod 4 of the 4x4 block.
REQ-022 Accepting lane 15 SHALL assert wr on the next cycle with the complete word, and waddr=(base_addr+word_index) mod 2^ADDR_W.
REQ-023 Throughput SHALL be one sample per cycle with no bubbles; the next word fills while the previous wr is issued.
REQ-024 Accepting lane 15 of word num_words-1 SHALL move FILL->LAST; in_ready=0 in LAST.
REQ-025 LAST: lasts one cycle, during which the final wr=1 is issued; then go to DONE.
REQ-026 DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
REQ-027 busy SHALL be 1 in FILL and LAST, and 0 in IDLE and DONE.
REQ-028 start asserted while not in IDLE SHALL be ignored, with no change to captured parameters.
REQ-029 in_valid=0 in FILL SHALL hold the lane counter and partial word; wr SHALL not assert.
REQ-030 Address wrap: base_addr+word_index beyond 2^ADDR_W-1 SHALL wrap to 0 without error.
REQ-031 wr SHALL be 0 except in the cycle after a lane-15 acceptance; wdata/waddr are don't-care while wr=0.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, lane/word counters 0, wr=0, waddr=0, wdata=0, in_ready=0, busy=0, done=0.
REQ-033 rst mid-transfer SHALL abandon the partial word with no further wr; no done pulse is produced.
REQ-034 After rst deasserts, the first start SHALL be accepted as in REQ-018.

Verification
REQ-035 start, base=0x0010, num_words=1; samples r=k, i=0x100+k for k=0..15, no gaps -> one wr, waddr=0x0010, lane k holds (k, 0x100+k); done 2 cycles after sample 15.
REQ-036 num_words=3 with continuous valid -> wr at 0x10, 0x11, 0x12, spaced exactly 16 cycles apart; busy high for 49 cycles.
REQ-037 base=0x1FFF, num_words=2 -> wr at waddr 0x1FFF, then at 0x0000.
REQ-038 Random in_valid gaps (50% duty), num_words=4 -> packed data identical to the gap-free run; wr count=4.
REQ-039 start with num_words=0 -> no wr, done one cycle later, busy never asserted.
REQ-040 rst asserted after 7 samples of word 0 -> outputs reach reset values immediately; no wr or done; a new start=1 afterwards completes normally.

Source files
------------

// File: rtl/image_mem_packer.sv
// rtl/image_mem_packer.sv - packs 16 complex samples per 1024-bit image memory word
module image_mem_packer #(
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_r,
    input  logic [31:0]       in_i,
    output logic              wr,
    output logic [ADDR_W-1:0] waddr,
    output logic [1023:0]     wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FILL, LAST, DONE} state_t;

    state_t             state;
    logic [3:0]         lane;
    logic [LEN_W-1:0]   word_idx;
    logic [LEN_W-1:0]   num_q;
    logic [ADDR_W-1:0]  base_q;
    logic               accept;

    assign in_ready = (state == FILL);
    assign busy     = (state == FILL) || (state == LAST);
    assign done     = (state == DONE);
    assign accept   = in_ready && in_valid;

    // Lanes land directly in wdata: lane 0 of the next word is written on the
    // edge that ends the wr cycle, so the presented word is never disturbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lane     <= 4'd0;
            word_idx <= '0;
            num_q    <= '0;
            base_q   <= '0;
            wr       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        num_q    <= num_words;
                        lane     <= 4'd0;
                        word_idx <= '0;
                        state    <= (num_words == '0) ? DONE : FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        wdata[{lane, 6'd0} +: 64] <= {in_i, in_r};
                        lane <= lane + 4'd1;
                        if (lane == 4'd15) begin
                            wr       <= 1'b1;
                            waddr    <= base_q + ADDR_W'(word_idx);
                            word_idx <= word_idx + LEN_W'(1);
                            if (word_idx == num_q - LEN_W'(1))
                                state <= LAST;
                        end
                    end
                end
                LAST:    state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_mem_packer.sv
// tb/tb_image_mem_packer.sv - randomized self-checking bench for image_mem_packer
module tb_image_mem_packer;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [12:0]   base_addr = '0;
    logic [13:0]   num_words = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_r = '0;
    logic [31:0]   in_i = '0;
    logic          wr;
    logic [12:0]   waddr;
    logic [1023:0] wdata;
    logic          busy;
    logic          done;

    image_mem_packer #(.ADDR_W(13), .LEN_W(14)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .wr(wr), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int busy_cycles = 0;
    int wr_times[$];
    logic [12:0]   exp_addr[$];
    logic [1023:0] exp_data[$];
    logic [12:0]   wr_addrs[$];
    logic [1023:0] last_wdata = '0;
    logic [31:0]   smp_r[0:127];
    logic [31:0]   smp_i[0:127];
    logic [1023:0] gapfree_words[0:3];

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Compare process: every write must match the head of the expected-word queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cycles++;
            if (done) done_cnt++;
            check("ready_implies_busy", {1023'd0, in_ready && !busy}, 1024'd0);
            check("busy_done_exclusive", {1023'd0, busy && done}, 1024'd0);
            if (wr) begin
                wr_cnt++;
                wr_times.push_back(cyc);
                wr_addrs.push_back(waddr);
                last_wdata = wdata;
                if (exp_addr.size() == 0) begin
                    check("unexpected_wr", 1024'd1, 1024'd0);
                end else begin
                    check("waddr", {1011'd0, waddr}, {1011'd0, exp_addr.pop_front()});
                    check("wdata", wdata, exp_data.pop_front());
                end
            end
        end
    end

    task automatic make_samples(input int n, input bit literal);
        for (int k = 0; k < 16 * n; k++) begin
            smp_r[k] = literal ? 32'(k) : $urandom;
            smp_i[k] = literal ? 32'h100 + 32'(k) : $urandom;
        end
    endtask

    task automatic expect_words(input logic [12:0] base, input int n);
        logic [1023:0] w;
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 16; k++)
                w[64*k +: 64] = {smp_i[16*j+k], smp_r[16*j+k]};
            exp_addr.push_back(base + 13'(j));
            exp_data.push_back(w);
        end
    endtask

    task automatic clear_stats();
        wr_cnt = 0;
        done_cnt = 0;
        busy_cycles = 0;
        wr_times.delete();
        wr_addrs.delete();
    endtask

    task automatic pulse_start(input logic [12:0] base, input logic [13:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns at posedge+1 right after the last wanted acceptance.
    task automatic drive_samples(input int total, input bit gaps, input bit poke);
        int idx = 0;
        int budget = 0;
        while (idx < total) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_r = smp_r[idx];
            in_i = smp_i[idx];
            start = poke && (idx == 20);
            if (start) begin base_addr = 13'h0700; num_words = 14'd5; end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            start = 1'b0;
            budget++;
            if (budget > 4000) begin
                check("sample_timeout", 1024'd1, 1024'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_xfer(input logic [12:0] base, input int n, input bit gaps, input bit poke);
        clear_stats();
        expect_words(base, n);
        pulse_start(base, 14'(n));
        drive_samples(16 * n, gaps, poke);
        @(negedge clk);
        check("last_busy", {1023'd0, busy}, 1024'd1);
        check("last_no_done", {1023'd0, done}, 1024'd0);
        check("last_not_ready", {1023'd0, in_ready}, 1024'd0);
        @(negedge clk);
        check("done_pulse", {1023'd0, done}, 1024'd1);
        check("done_not_busy", {1023'd0, busy}, 1024'd0);
        @(negedge clk);
        check("done_single", {1023'd0, done}, 1024'd0);
        check("wr_count", 1024'(wr_cnt), 1024'(n));
        check("done_count", 1024'(done_cnt), 1024'd1);
        check("exp_drained", 1024'(exp_addr.size()), 1024'd0);
        if (!gaps) check("busy_cycles", 1024'(busy_cycles), 1024'(16 * n + 1));
    endtask

    initial begin
        #1;
        check("rst_wr", {1023'd0, wr}, 1024'd0);
        check("rst_waddr", {1011'd0, waddr}, 1024'd0);
        check("rst_wdata", wdata, 1024'd0);
        check("rst_ready", {1023'd0, in_ready}, 1024'd0);
        check("rst_busy", {1023'd0, busy}, 1024'd0);
        check("rst_done", {1023'd0, done}, 1024'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        make_samples(1, 1'b1);
        run_xfer(13'h0010, 1, 1'b0, 1'b0);
        check("lit_waddr", {1011'd0, wr_addrs[0]}, {1011'd0, 13'h0010});
        check("lit_lane0", {960'd0, last_wdata[63:0]}, {960'd0, 64'h00000100_00000000});
        check("lit_lane3", {960'd0, last_wdata[3*64 +: 64]}, {960'd0, 64'h00000103_00000003});
        check("lit_lane15", {960'd0, last_wdata[15*64 +: 64]}, {960'd0, 64'h0000010f_0000000f});

        make_samples(3, 1'b0);
        run_xfer(13'h0010, 3, 1'b0, 1'b1);
        check("lit_w3_addr2", {1011'd0, wr_addrs[2]}, {1011'd0, 13'h0012});
        check("spacing01", 1024'(wr_times[1] - wr_times[0]), 1024'd16);
        check("spacing12", 1024'(wr_times[2] - wr_times[1]), 1024'd16);
        check("lit_busy49", 1024'(busy_cycles), 1024'd49);

        make_samples(2, 1'b0);
        run_xfer(13'h1FFF, 2, 1'b0, 1'b0);
        check("wrap_a0", {1011'd0, wr_addrs[0]}, {1011'd0, 13'h1FFF});
        check("wrap_a1", {1011'd0, wr_addrs[1]}, 1024'd0);

        make_samples(4, 1'b0);
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 16; k++)
                gapfree_words[j][64*k +: 64] = {smp_i[16*j+k], smp_r[16*j+k]};
        run_xfer(13'h0123, 4, 1'b0, 1'b0);
        run_xfer(13'h0123, 4, 1'b1, 1'b0);
        check("gap_last_word", last_wdata, gapfree_words[3]);

        clear_stats();
        pulse_start(13'h0042, 14'd0);
        @(negedge clk);
        check("zero_done", {1023'd0, done}, 1024'd1);
        repeat (3) @(negedge clk);
        check("zero_no_wr", 1024'(wr_cnt), 1024'd0);
        check("zero_no_busy", 1024'(busy_cycles), 1024'd0);
        check("zero_done_cnt", 1024'(done_cnt), 1024'd1);

        clear_stats();
        make_samples(1, 1'b0);
        pulse_start(13'h0005, 14'd1);
        drive_samples(7, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_wr", {1023'd0, wr}, 1024'd0);
        check("mid_rst_waddr", {1011'd0, waddr}, 1024'd0);
        check("mid_rst_wdata", wdata, 1024'd0);
        check("mid_rst_ready", {1023'd0, in_ready}, 1024'd0);
        check("mid_rst_busy", {1023'd0, busy}, 1024'd0);
        check("mid_rst_done", {1023'd0, done}, 1024'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_wr", 1024'(wr_cnt), 1024'd0);
        check("mid_rst_no_done", 1024'(done_cnt), 1024'd0);

        make_samples(2, 1'b0);
        run_xfer(13'h0777, 2, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
